// File: rtl/swap_pkg.sv
// Shared types and constants for the register-exchange engine.
package swap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SAVE      = 3'd1,
        ST_MOVE      = 3'd2,
        ST_RESTORE   = 3'd3,
        ST_ROT_SAVE  = 3'd4,
        ST_ROT_SHIFT = 3'd5,
        ST_ROT_WRAP  = 3'd6
    } state_e;

    localparam logic MODE_SWAP = 1'b0;
    localparam logic MODE_ROT  = 1'b1;

endpackage

// File: rtl/swap_engine_if.sv
// Host-side bundle of the swap engine: start handshake, load port and readback port.
interface swap_engine_if #(
    parameter int WIDTH = 6,
    parameter int NREGS = 4
);
    localparam int IDXW = $clog2(NREGS);

    logic             w;
    logic             mode;
    logic [IDXW-1:0]  idx_a;
    logic [IDXW-1:0]  idx_b;
    logic             wr_en;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [IDXW-1:0]  rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             done;
    logic             err;

    modport master (
        output w, mode, idx_a, idx_b, wr_en, wr_idx, wr_data, rd_idx,
        input  rd_data, done, err
    );

    modport slave (
        input  w, mode, idx_a, idx_b, wr_en, wr_idx, wr_data, rd_idx,
        output rd_data, done, err
    );
endinterface

// File: rtl/swap_regfile.sv
// NREGS x WIDTH register bank: one write port, FSM read port and host read port.
module swap_regfile #(
    parameter int WIDTH = 6,
    parameter int NREGS = 4,
    parameter int IDXW  = $clog2(NREGS)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             we,
    input  logic [IDXW-1:0]  widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDXW-1:0]  fsm_idx,
    output logic [WIDTH-1:0] fsm_data,
    input  logic [IDXW-1:0]  host_idx,
    output logic [WIDTH-1:0] host_data
);

    logic [WIDTH-1:0] regs_r [NREGS];

    function automatic logic in_range(input logic [IDXW-1:0] i);
        return (int'(i) < NREGS);
    endfunction

    // Bank storage: reset to the i+1 pattern, otherwise single-port write.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= WIDTH'(i + 1);
            end
        end else if (we && in_range(widx)) begin
            regs_r[widx] <= wdata;
        end
    end

    // Read ports; an out-of-range index reads as zero.
    always_comb begin
        fsm_data  = {WIDTH{1'b0}};
        host_data = {WIDTH{1'b0}};
        if (in_range(fsm_idx)) begin
            fsm_data = regs_r[fsm_idx];
        end else begin
            fsm_data = {WIDTH{1'b0}};
        end
        if (in_range(host_idx)) begin
            host_data = regs_r[host_idx];
        end else begin
            host_data = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/swap_engine.sv
// Register-exchange engine: swaps two registers or rotates the bank left,
// moving data through a single temp register one write per cycle.
module swap_engine
    import swap_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int NREGS = 4
) (
    input  logic          ck,
    input  logic          rst,
    swap_engine_if.slave  bus
);

    localparam int IDXW = $clog2(NREGS);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREGS - 1);
    localparam logic [IDXW-1:0] SHIFT_END = IDXW'(NREGS - 2);

    state_e           state_r, next_state_s;
    logic [IDXW-1:0]  a_r, b_r, k_r;
    logic [WIDTH-1:0] tmp_r;
    logic             err_r;

    logic             rf_we_s;
    logic [IDXW-1:0]  rf_widx_s;
    logic [WIDTH-1:0] rf_wdata_s;
    logic [IDXW-1:0]  fsm_ridx_s;
    logic [WIDTH-1:0] fsm_rdata_s;
    logic             tmp_load_s;
    logic             latch_idx_s;
    logic             k_clr_s;
    logic             k_inc_s;
    logic             err_set_s;

    function automatic logic in_range(input logic [IDXW-1:0] i);
        return (int'(i) < NREGS);
    endfunction

    swap_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .IDXW(IDXW)) u_regfile (
        .ck        (ck),
        .rst       (rst),
        .we        (rf_we_s),
        .widx      (rf_widx_s),
        .wdata     (rf_wdata_s),
        .fsm_idx   (fsm_ridx_s),
        .fsm_data  (fsm_rdata_s),
        .host_idx  (bus.rd_idx),
        .host_data (bus.rd_data)
    );

    // Next-state decode and the single register-file write of this cycle.
    always_comb begin
        next_state_s = state_r;
        rf_we_s      = 1'b0;
        rf_widx_s    = {IDXW{1'b0}};
        rf_wdata_s   = {WIDTH{1'b0}};
        fsm_ridx_s   = {IDXW{1'b0}};
        tmp_load_s   = 1'b0;
        latch_idx_s  = 1'b0;
        k_clr_s      = 1'b0;
        k_inc_s      = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A start request, even a rejected one, suppresses the host write.
                if (bus.w) begin
                    if (bus.mode == MODE_ROT) begin
                        next_state_s = ST_ROT_SAVE;
                        k_clr_s      = 1'b1;
                    end else if (in_range(bus.idx_a) && in_range(bus.idx_b)) begin
                        next_state_s = ST_SAVE;
                        latch_idx_s  = 1'b1;
                    end else begin
                        err_set_s    = 1'b1;
                    end
                end else if (bus.wr_en) begin
                    rf_we_s    = 1'b1;
                    rf_widx_s  = bus.wr_idx;
                    rf_wdata_s = bus.wr_data;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SAVE: begin
                fsm_ridx_s   = a_r;
                tmp_load_s   = 1'b1;
                next_state_s = ST_MOVE;
            end
            ST_MOVE: begin
                fsm_ridx_s   = b_r;
                rf_we_s      = 1'b1;
                rf_widx_s    = a_r;
                rf_wdata_s   = fsm_rdata_s;
                next_state_s = ST_RESTORE;
            end
            ST_RESTORE: begin
                rf_we_s      = 1'b1;
                rf_widx_s    = b_r;
                rf_wdata_s   = tmp_r;
                next_state_s = ST_IDLE;
            end
            ST_ROT_SAVE: begin
                fsm_ridx_s   = {IDXW{1'b0}};
                tmp_load_s   = 1'b1;
                next_state_s = ST_ROT_SHIFT;
            end
            ST_ROT_SHIFT: begin
                fsm_ridx_s = k_r + 1'b1;
                rf_we_s    = 1'b1;
                rf_widx_s  = k_r;
                rf_wdata_s = fsm_rdata_s;
                k_inc_s    = 1'b1;
                if (k_r == SHIFT_END) begin
                    next_state_s = ST_ROT_WRAP;
                end else begin
                    next_state_s = ST_ROT_SHIFT;
                end
            end
            ST_ROT_WRAP: begin
                rf_we_s      = 1'b1;
                rf_widx_s    = LAST_IDX;
                rf_wdata_s   = tmp_r;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched indices, temp, step counter and error pulse.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= {IDXW{1'b0}};
            b_r     <= {IDXW{1'b0}};
            k_r     <= {IDXW{1'b0}};
            tmp_r   <= {WIDTH{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            err_r   <= err_set_s;
            if (latch_idx_s) begin
                a_r <= bus.idx_a;
                b_r <= bus.idx_b;
            end
            if (tmp_load_s) begin
                tmp_r <= fsm_rdata_s;
            end
            if (k_clr_s) begin
                k_r <= {IDXW{1'b0}};
            end else if (k_inc_s) begin
                k_r <= k_r + 1'b1;
            end
        end
    end

    assign bus.done = (state_r == ST_IDLE);
    assign bus.err  = err_r;

endmodule

// File: tb/tb_swap_engine.sv
// Directed bench for swap_engine: a 4-register and a 3-register instance.
module tb_swap_engine;

    logic ck  = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 ck = ~ck;

    swap_engine_if #(.WIDTH(6), .NREGS(4)) sif4 ();
    swap_engine_if #(.WIDTH(6), .NREGS(3)) sif3 ();

    swap_engine #(.WIDTH(6), .NREGS(4)) dut4 (.ck(ck), .rst(rst), .bus(sif4));
    swap_engine #(.WIDTH(6), .NREGS(3)) dut3 (.ck(ck), .rst(rst), .bus(sif3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic rd4(input logic [1:0] idx, input logic [5:0] exp, input string tag);
        sif4.rd_idx = idx;
        #1;
        check(tag, {26'd0, sif4.rd_data}, {26'd0, exp});
    endtask

    task automatic rd3(input logic [1:0] idx, input logic [5:0] exp, input string tag);
        sif3.rd_idx = idx;
        #1;
        check(tag, {26'd0, sif3.rd_data}, {26'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        sif4.w = 1'b0; sif4.mode = 1'b0; sif4.idx_a = 2'd0; sif4.idx_b = 2'd0;
        sif4.wr_en = 1'b0; sif4.wr_idx = 2'd0; sif4.wr_data = 6'd0; sif4.rd_idx = 2'd0;
        sif3.w = 1'b0; sif3.mode = 1'b0; sif3.idx_a = 2'd0; sif3.idx_b = 2'd0;
        sif3.wr_en = 1'b0; sif3.wr_idx = 2'd0; sif3.wr_data = 6'd0; sif3.rd_idx = 2'd0;

        // Reset state
        do_reset();
        check("reset_done", {31'd0, sif4.done}, 32'd1);
        check("reset_err", {31'd0, sif4.err}, 32'd0);
        rd4(2'd0, 6'd1, "reset_r0");
        rd4(2'd1, 6'd2, "reset_r1");
        rd4(2'd2, 6'd3, "reset_r2");
        rd4(2'd3, 6'd4, "reset_r3");

        // Swap r0 <-> r2
        sif4.w = 1'b1; sif4.mode = 1'b0; sif4.idx_a = 2'd0; sif4.idx_b = 2'd2;
        step();
        sif4.w = 1'b0;
        check("swap_busy0", {31'd0, sif4.done}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            step();
            check("swap_busy", {31'd0, sif4.done}, 32'd0);
        end
        step();
        check("swap_done", {31'd0, sif4.done}, 32'd1);
        rd4(2'd0, 6'd3, "swap_r0");
        rd4(2'd1, 6'd2, "swap_r1");
        rd4(2'd2, 6'd1, "swap_r2");
        rd4(2'd3, 6'd4, "swap_r3");

        // Rotate-left from reset contents
        do_reset();
        sif4.w = 1'b1; sif4.mode = 1'b1;
        step();
        sif4.w = 1'b0;
        check("rot_busy0", {31'd0, sif4.done}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            step();
            check("rot_busy", {31'd0, sif4.done}, 32'd0);
        end
        step();
        check("rot_done", {31'd0, sif4.done}, 32'd1);
        rd4(2'd0, 6'd2, "rot_r0");
        rd4(2'd1, 6'd3, "rot_r1");
        rd4(2'd2, 6'd4, "rot_r2");
        rd4(2'd3, 6'd1, "rot_r3");

        // Host write r1 = 63, then self-swap on r1; bank becomes 2,63,4,1
        sif4.wr_en = 1'b1; sif4.wr_idx = 2'd1; sif4.wr_data = 6'd63;
        step();
        sif4.wr_en = 1'b0;
        rd4(2'd1, 6'd63, "wr_r1");
        sif4.w = 1'b1; sif4.mode = 1'b0; sif4.idx_a = 2'd1; sif4.idx_b = 2'd1;
        step();
        sif4.w = 1'b0;
        step();
        step();
        check("self_busy", {31'd0, sif4.done}, 32'd0);
        step();
        check("self_done", {31'd0, sif4.done}, 32'd1);
        rd4(2'd1, 6'd63, "self_r1");
        rd4(2'd0, 6'd2, "self_r0");

        // Write together with start: swap r2/r3 wins, write to r0 dropped
        sif4.wr_en = 1'b1; sif4.wr_idx = 2'd0; sif4.wr_data = 6'd5;
        sif4.w = 1'b1; sif4.mode = 1'b0; sif4.idx_a = 2'd2; sif4.idx_b = 2'd3;
        step();
        sif4.w = 1'b0; sif4.wr_en = 1'b0;
        step();
        step();
        step();
        check("drop_done", {31'd0, sif4.done}, 32'd1);
        rd4(2'd0, 6'd2, "drop_r0");
        rd4(2'd2, 6'd1, "drop_r2");
        rd4(2'd3, 6'd4, "drop_r3");

        // Reset during MOVE of a 0<->2 swap
        do_reset();
        sif4.w = 1'b1; sif4.mode = 1'b0; sif4.idx_a = 2'd0; sif4.idx_b = 2'd2;
        step();
        sif4.w = 1'b0;
        step();
        check("abort_in_move", {31'd0, sif4.done}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_done", {31'd0, sif4.done}, 32'd1);
        check("abort_tmp", {26'd0, dut4.tmp_r}, 32'd0);
        rd4(2'd0, 6'd1, "abort_r0");
        rd4(2'd1, 6'd2, "abort_r1");
        rd4(2'd2, 6'd3, "abort_r2");
        rd4(2'd3, 6'd4, "abort_r3");

        // NREGS=3: out-of-range swap index is rejected
        sif3.w = 1'b1; sif3.mode = 1'b0; sif3.idx_a = 2'd3; sif3.idx_b = 2'd0;
        step();
        sif3.w = 1'b0;
        check("n3_err_pulse", {31'd0, sif3.err}, 32'd1);
        check("n3_err_done", {31'd0, sif3.done}, 32'd1);
        step();
        check("n3_err_clear", {31'd0, sif3.err}, 32'd0);
        rd3(2'd0, 6'd1, "n3_r0");
        rd3(2'd1, 6'd2, "n3_r1");
        rd3(2'd2, 6'd3, "n3_r2");
        rd3(2'd3, 6'd0, "n3_rd_oor");

        // NREGS=3: out-of-range host write changes nothing
        sif3.wr_en = 1'b1; sif3.wr_idx = 2'd3; sif3.wr_data = 6'd7;
        step();
        sif3.wr_en = 1'b0;
        rd3(2'd0, 6'd1, "n3_woor_r0");
        rd3(2'd1, 6'd2, "n3_woor_r1");
        rd3(2'd2, 6'd3, "n3_woor_r2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/swap_engine.md
Name: swap_engine

Overview:
- Parametrised register-exchange engine: NREGS registers of WIDTH bits, exchanged through one temp register by a multi-cycle FSM.
- Modes: swap any two indexed registers, or rotate the whole bank left by one position.
- Host-side load and readback ports.
- Used by datapath control blocks that reorder small operand sets; handshake is start (w) in, done out.

Parameters:
- WIDTH, 6, bit width of each register and of temp.
- NREGS, 4, number of registers; legal range 2..16.
- IDXW, $clog2(NREGS), index width; derived, not overridden.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- w  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = swap, 1 = rotate-left; sampled with w.
- idx_a  in  IDXW  first swap index; sampled with w.
- idx_b  in  IDXW  second swap index; sampled with w.
- wr_en  in  1  host write strobe.
- wr_idx  in  IDXW  host write index.
- wr_data  in  WIDTH  host write data.
- rd_idx  in  IDXW  host read index.
- rd_data  out  WIDTH  combinational r[rd_idx]; 0 if rd_idx >= NREGS.
- done  out  1  high exactly when state == IDLE.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset, applied on the ck edge where rst=1:
  - state = IDLE, done = 1, err = 0, tmp = 0.
  - r[i] = (i+1) mod 2^WIDTH.
  - rst has priority over every other input, including mid-operation: the operation is aborted and all registers return to their reset values.
- FSM states: IDLE, SAVE, MOVE, RESTORE, ROT_SAVE, ROT_SHIFT, ROT_WRAP.
- IDLE:
  - w=1, mode=0, both indices < NREGS: latch idx_a/idx_b, go to SAVE.
  - w=1, mode=1: go to ROT_SAVE, step counter = 0.
  - w=1, mode=0, either index >= NREGS: err=1 for one cycle, stay IDLE, no register changes.
  - w=0: stay IDLE.
- Swap sequence:
  - SAVE: tmp <= r[a]; next MOVE.
  - MOVE: r[a] <= r[b]; next RESTORE.
  - RESTORE: r[b] <= tmp; next IDLE.
  - done is low for exactly 3 cycles after the accepting edge.
  - idx_a == idx_b: runs the full 3 cycles; contents unchanged.
- Rotate sequence:
  - ROT_SAVE: tmp <= r[0]; next ROT_SHIFT.
  - ROT_SHIFT: r[k] <= r[k+1], k increments each cycle; after k = NREGS-2, next ROT_WRAP.
  - ROT_WRAP: r[NREGS-1] <= tmp; next IDLE.
  - done is low for NREGS+1 cycles.
- Host writes:
  - Honoured only in IDLE when no start is accepted on the same edge; start wins and the write is dropped.
  - wr_en outside IDLE is ignored.
  - wr_idx >= NREGS: no register changes.
- Internal writes: at most one register write per cycle.
- Back-to-back operation: w held high re-accepts on the first IDLE cycle, so done is high for one cycle between operations.
- Inputs other than w/mode/idx are don't-care while busy.

Decomposition:
- Package swap_pkg:
  - state enum (3-bit).
  - MODE_SWAP = 0, MODE_ROT = 1.
- Sub-module swap_regfile:
  - NREGS x WIDTH array, one write port, two combinational read ports (FSM read, host read), synchronous reset to the i+1 pattern.
- FSM, temp register and step counter stay in swap_engine.

Test Plan:
- Reset, then read all indices with NREGS=4, WIDTH=6 -> rd_data = 1, 2, 3, 4; done = 1.
- w=1, mode=0, a=0, b=2 -> done low 3 cycles; readback 3, 2, 1, 4.
- w=1, mode=1 from reset contents -> done low 5 cycles; readback 2, 3, 4, 1.
- Write r[1] = 63 in IDLE, then swap a=1, b=1 -> r[1] stays 63 after 3 cycles. Separately, wr_en asserted together with w -> write dropped.
- NREGS=3, start swap with a=3 -> err pulses one cycle, done stays 1, contents unchanged.
- rst=1 at MOVE of a 0<->2 swap -> next cycle IDLE; contents 1, 2, 3, 4; tmp = 0.
